// File: rtl/sub_bytes_engine.sv
// -----------------------------------------------------------------------------
// sub_bytes_engine
//   Sequential AES byte-substitution stage. It applies forward SubBytes or
//   InvSubBytes to a 128-bit state and processes LANES bytes per clock, so a
//   block takes 16/LANES cycles. The mode is chosen per block. A round tag
//   travels with the state unchanged. The block sits between the round-key
//   adder and ShiftRows / InvShiftRows in an iterative AES datapath.
//
// Parameters
//   LANES    bytes substituted per cycle (1, 2, 4, 8 or 16)
//   ROUND_W  width of the round tag carried alongside the state
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        input block valid
//   in_ready   out  1        engine can accept a block (high only in IDLE)
//   in_data    in   128      state, byte i = bits [8i+7:8i]
//   in_mode    in   1        0 = SubBytes, 1 = InvSubBytes
//   in_round   in   ROUND_W  round tag, echoed on out_round
//   out_valid  out  1        result valid, held until out_ready
//   out_ready  in   1        downstream accepts the result
//   out_data   out  128      substituted state
//   out_round  out  ROUND_W  round tag latched at accept
//   busy       out  1        high while a block is in RUN or DONE
// -----------------------------------------------------------------------------
module sub_bytes_engine #(
  parameter int LANES   = 4,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  input  logic               in_mode,
  input  logic [ROUND_W-1:0] in_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic [ROUND_W-1:0] out_round,
  output logic               busy
);

  localparam int NCH     = 16 / LANES;
  localparam int CHUNK_W = 8 * LANES;
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

  // Only a power-of-two lane count that divides the 16-byte state is supported.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers. The S-box is built from the multiplicative inverse and
  // the FIPS-197 affine map. This keeps the source compact and leaves the
  // 256-entry table to synthesis.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (aa & {8{b[i]}});
      aa  = gf_xtime(aa);
    end
    return acc;
  endfunction

  // The inverse is computed as x^254. The inverse of 0 comes out as 0, which
  // is what the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return affine_fwd(gf_inv(x));
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(affine_inv(x));
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [127:0]       work_q;
  logic [127:0]       work_d;
  logic               mode_q;
  logic [ROUND_W-1:0] round_q;
  logic               out_valid_q;
  logic [127:0]       out_data_q;
  logic [ROUND_W-1:0] out_round_q;
  logic               busy_q;

  logic [6:0]         chunk_lsb_s;
  logic [CHUNK_W-1:0] chunk_s;
  logic [CHUNK_W-1:0] sub_chunk_s;

  // Select the chunk named by the counter. The MSB chunk comes first, so
  // chunk k starts at bit CHUNK_W*(NCH-1-k).
  always_comb begin
    chunk_lsb_s = 7'((NCH - 1 - int'(cnt_q)) * CHUNK_W);
    chunk_s     = work_q[chunk_lsb_s +: CHUNK_W];
  end

  // One forward S-box and one inverse S-box per lane. The block mode picks
  // which result is used.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] fwd_s;
    logic [7:0] inv_s;

    // Per-lane lookups on the current chunk.
    always_comb begin
      fwd_s = sbox_fwd(chunk_s[8*l +: 8]);
      inv_s = sbox_inv(chunk_s[8*l +: 8]);
    end

    assign sub_chunk_s[8*l +: 8] = mode_q ? inv_s : fwd_s;
  end

  // The working state with the current chunk substituted in place.
  always_comb begin
    work_d = work_q;
    work_d[chunk_lsb_s +: CHUNK_W] = sub_chunk_s;
  end

  // Control FSM with its registered outputs. The counter stops at NCH-1 and
  // never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      work_q      <= 128'h0;
      mode_q      <= 1'b0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 128'h0;
      out_round_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_q  <= in_data;
            mode_q  <= in_mode;
            round_q <= in_round;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          work_q <= work_d;
          if (cnt_q == LAST_CNT) begin
            out_data_q  <= work_d;
            out_round_q <= round_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  // in_ready is decoded directly from the state register, so it reads 1
  // while reset is asserted.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_round = out_round_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_engine
//   Five engines are instantiated, with LANES = 1, 2, 4, 8 and 16. They share
//   the clock and reset and have separate handshake signals. The reference
//   S-box tables are generated with the multiply-by-3 / divide-by-3 walk over
//   GF(2^8), and the inverse table is filled by inverting the forward table.
// -----------------------------------------------------------------------------
module tb_sub_bytes_engine;

  localparam int NDUT = 5;
  localparam int MAIN = 2;
  localparam int LANES_TAB [NDUT] = '{1, 2, 4, 8, 16};

  localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_SUB = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic clk;
  logic rst;

  logic         in_valid_s  [NDUT];
  logic         in_ready_s  [NDUT];
  logic [127:0] in_data_s   [NDUT];
  logic         in_mode_s   [NDUT];
  logic [3:0]   in_round_s  [NDUT];
  logic         out_valid_s [NDUT];
  logic         out_ready_s [NDUT];
  logic [127:0] out_data_s  [NDUT];
  logic [3:0]   out_round_s [NDUT];
  logic         busy_s      [NDUT];

  int checks;
  int errors;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sub_bytes_engine #(.LANES(LANES_TAB[g]), .ROUND_W(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .in_data   (in_data_s[g]),
      .in_mode   (in_mode_s[g]),
      .in_round  (in_round_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .out_data  (out_data_s[g]),
      .out_round (out_round_s[g]),
      .busy      (busy_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Walk the multiplicative group with generator 3. p steps through the
  // powers of 3 and q holds the matching inverse.
  task automatic build_model();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
      fwd_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_tab[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] x, input logic m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = m ? inv_tab[x[8*i +: 8]] : fwd_tab[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Runs one complete transaction on engine d. Outputs are sampled 1 ns after
  // each rising edge. lat counts the edges from the accept edge to out_valid.
  task automatic run_block(input int d, input logic [127:0] data, input logic mode,
                           input logic [3:0] rnd, input int gap, input int stall,
                           output logic [127:0] res, output logic [3:0] res_round,
                           output int lat);
    int waitc;
    repeat (gap) begin @(posedge clk); #1; end
    waitc = 0;
    while (!in_ready_s[d] && waitc < 100) begin @(posedge clk); #1; waitc++; end
    if (!in_ready_s[d]) chk("in_ready_timeout", 128'(in_ready_s[d]), 128'(1));
    in_valid_s[d] = 1'b1;
    in_data_s[d]  = data;
    in_mode_s[d]  = mode;
    in_round_s[d] = rnd;
    @(posedge clk); #1;
    // Change the inputs after the accept edge. The engine must ignore them.
    in_valid_s[d] = 1'b0;
    in_data_s[d]  = rnd128();
    in_mode_s[d]  = ~mode;
    in_round_s[d] = ~rnd;
    chk("busy_after_accept", 128'({busy_s[d], in_ready_s[d]}), 128'(2'b10));
    lat = 0;
    while (!out_valid_s[d] && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid_s[d]) chk("out_valid_timeout", 128'(out_valid_s[d]), 128'(1));
    res       = out_data_s[d];
    res_round = out_round_s[d];
    for (int s = 0; s < stall; s++) begin
      chk("stall_hold", {out_data_s[d] ^ res, 1'b0} | 128'({out_valid_s[d], in_ready_s[d]}),
          128'(2'b10));
      @(posedge clk); #1;
    end
    out_ready_s[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[d] = 1'b0;
    chk("out_valid_drop", 128'({out_valid_s[d], busy_s[d], in_ready_s[d]}), 128'(3'b001));
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] res2;
    logic [3:0]   rr;
    int           lat;
    logic [127:0] cap;
    logic [127:0] blk;
    logic         m;
    logic [3:0]   tag;
    logic         seen;
    int           waitc;

    checks = 0;
    errors = 0;
    build_model();
    for (int d = 0; d < NDUT; d++) begin
      in_valid_s[d]  = 1'b0;
      in_data_s[d]   = 128'h0;
      in_mode_s[d]   = 1'b0;
      in_round_s[d]  = 4'h0;
      out_ready_s[d] = 1'b0;
    end

    // Reset state. in_valid is driven high to show it is ignored while rst=1.
    rst = 1'b1;
    in_valid_s[MAIN] = 1'b1;
    in_data_s[MAIN]  = VEC_PT;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid_s[MAIN]), 128'(0));
    chk("rst_out_data", out_data_s[MAIN], 128'h0);
    chk("rst_out_round", 128'(out_round_s[MAIN]), 128'(0));
    chk("rst_busy_ready", 128'({busy_s[MAIN], in_ready_s[MAIN]}), 128'(2'b01));
    in_valid_s[MAIN] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Forward known-answer vector with LANES=4.
    run_block(MAIN, VEC_PT, 1'b0, 4'h3, 0, 0, res, rr, lat);
    chk("t1_data", res, VEC_SUB);
    chk("t1_model", res, ref_sub(VEC_PT, 1'b0));
    chk("t1_latency", 128'(lat), 128'(4));
    chk("t1_round", 128'(rr), 128'(4'h3));

    // The inverse of the forward result restores the plaintext and echoes the tag.
    run_block(MAIN, res, 1'b1, 4'hA, 1, 0, res2, rr, lat);
    chk("t2_data", res2, VEC_PT);
    chk("t2_round", 128'(rr), 128'(4'hA));

    // Backpressure. in_valid is held high with a second block through the
    // stall, and that block may only be accepted after the release.
    blk = rnd128();
    in_valid_s[MAIN] = 1'b1;
    in_data_s[MAIN]  = VEC_PT;
    in_mode_s[MAIN]  = 1'b0;
    in_round_s[MAIN] = 4'h5;
    @(posedge clk); #1;
    in_data_s[MAIN]  = blk;
    in_mode_s[MAIN]  = 1'b1;
    in_round_s[MAIN] = 4'h6;
    waitc = 0;
    while (!out_valid_s[MAIN] && waitc < 50) begin @(posedge clk); #1; waitc++; end
    chk("t3_valid_seen", 128'(out_valid_s[MAIN]), 128'(1));
    cap = out_data_s[MAIN];
    chk("t3_data", cap, VEC_SUB);
    chk("t3_round", 128'(out_round_s[MAIN]), 128'(4'h5));
    for (int s = 0; s < 10; s++) begin
      chk("t3_hold", {out_data_s[MAIN] ^ cap, 1'b0} |
          128'({out_valid_s[MAIN], in_ready_s[MAIN], busy_s[MAIN]}), 128'(3'b101));
      @(posedge clk); #1;
    end
    out_ready_s[MAIN] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[MAIN] = 1'b0;
    chk("t3_release", 128'({out_valid_s[MAIN], in_ready_s[MAIN], busy_s[MAIN]}), 128'(3'b010));
    @(posedge clk); #1;
    in_valid_s[MAIN] = 1'b0;
    chk("t3_second_accept", 128'({busy_s[MAIN], in_ready_s[MAIN]}), 128'(2'b10));
    waitc = 0;
    while (!out_valid_s[MAIN] && waitc < 50) begin @(posedge clk); #1; waitc++; end
    chk("t3_second_data", out_data_s[MAIN], ref_sub(blk, 1'b1));
    chk("t3_second_round", 128'(out_round_s[MAIN]), 128'(4'h6));
    out_ready_s[MAIN] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[MAIN] = 1'b0;

    // Reset asserted during the second RUN cycle.
    blk = rnd128();
    in_valid_s[MAIN] = 1'b1;
    in_data_s[MAIN]  = blk;
    in_mode_s[MAIN]  = 1'b0;
    in_round_s[MAIN] = 4'h7;
    @(posedge clk); #1;
    in_valid_s[MAIN] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t4_rst_state", 128'({out_valid_s[MAIN], in_ready_s[MAIN], busy_s[MAIN]}), 128'(3'b010));
    in_valid_s[MAIN] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid_s[MAIN] = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen = seen | out_valid_s[MAIN]; end
    chk("t4_no_out_valid", 128'({seen, in_ready_s[MAIN]}), 128'(2'b01));
    run_block(MAIN, blk, 1'b0, 4'h7, 0, 0, res, rr, lat);
    chk("t4_after_reset", res, ref_sub(blk, 1'b0));

    // Specific bytes: 0x53 maps to 0xED forward, 0x63 maps to 0x00 inverse.
    run_block(MAIN, {16{8'h53}}, 1'b0, 4'h1, 0, 0, res, rr, lat);
    chk("byte_53_fwd", res, {16{8'hED}});
    run_block(MAIN, {16{8'h63}}, 1'b1, 4'h2, 0, 0, res, rr, lat);
    chk("byte_63_inv", res, 128'h0);

    // Lane sweep: the same vectors with latency 16/LANES, plus a few random blocks.
    for (int d = 0; d < NDUT; d++) begin
      if (d != MAIN) begin
        run_block(d, VEC_PT, 1'b0, 4'h9, 0, 0, res, rr, lat);
        chk("t5_data", res, VEC_SUB);
        chk("t5_latency", 128'(lat), 128'(16 / LANES_TAB[d]));
        chk("t5_round", 128'(rr), 128'(4'h9));
        run_block(d, res, 1'b1, 4'h4, 0, 1, res2, rr, lat);
        chk("t5_inverse", res2, VEC_PT);
        for (int n = 0; n < 20; n++) begin
          blk = rnd128();
          m   = 1'($urandom_range(0, 1));
          tag = 4'($urandom_range(0, 15));
          run_block(d, blk, m, tag, $urandom_range(0, 2), $urandom_range(0, 2), res, rr, lat);
          chk("t5_rand_data", res, ref_sub(blk, m));
        end
      end
    end

    // 1000 random blocks with random mode, input gaps and output stalls.
    for (int n = 0; n < 1000; n++) begin
      blk = rnd128();
      m   = 1'($urandom_range(0, 1));
      tag = 4'($urandom_range(0, 15));
      run_block(MAIN, blk, m, tag, $urandom_range(0, 3), $urandom_range(0, 3), res, rr, lat);
      chk("t6_data", res, ref_sub(blk, m));
      chk("t6_round", 128'(rr), 128'(tag));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
